// File: rtl/neo_bus_pkg.sv
// Shared types and constants for the NeoGeo 68k bus responder slice.
package neo_bus_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;
  localparam int WCNT_W = 4;
  localparam int TCNT_W = 10;

  // Value returned to the CPU when the backend never answers.
  localparam logic [DATA_W-1:0] OPEN_BUS = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } bus_state_t;

  // True when the word address falls inside the decoded window.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/m68k_bus_wdog.sv
// Backend timeout watchdog: saturating cycle counter with a terminal compare.
module m68k_bus_wdog
  import neo_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic CLK_24M,
  input  logic nRESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = '1;

  logic [TCNT_W-1:0] tcnt;

  // Count cycles spent waiting on the backend; hold at the top value rather than wrap.
  always_ff @(posedge CLK_24M) begin
    if (!nRESET || clear) begin
      tcnt <= '0;
    end else if (enable && (tcnt != TCNT_MAX)) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign expired = enable && (tcnt == TCNT_LAST);

endmodule

// File: rtl/m68k_bus_responder.sv
// Target-side 68000 bus responder: turns one CPU bus cycle into one backend
// req/ack transaction, enforces a minimum wait-state count before nDTACK,
// and forces completion with open-bus data if the backend goes silent.
module m68k_bus_responder
  import neo_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_BASE   = 23'h000000,
  parameter logic [ADDR_W-1:0] ADDR_MASK   = 23'h780000,
  parameter int unsigned       WAIT_STATES = 2,
  parameter int unsigned       TIMEOUT     = 255
) (
  input  logic              CLK_24M,
  input  logic              nRESET,
  input  logic [ADDR_W-1:0] M68K_ADDR,
  input  logic [DATA_W-1:0] M68K_DATA_W,
  output logic [DATA_W-1:0] M68K_DATA_R,
  input  logic              nAS,
  input  logic              nUDS,
  input  logic              nLDS,
  input  logic              M68K_RW,
  output logic              nDTACK,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [1:0]        MEM_BE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  output logic              TIMEOUT_ERR
);

  bus_state_t state, state_next;

  logic [WCNT_W-1:0] wcnt;
  logic              cycle_start;
  logic              wait_done;
  logic              tmo_expired;
  logic              wdog_clear;
  logic              wdog_enable;

  logic latch_bus;
  logic req_drop;
  logic rdata_load;
  logic rdata_open;
  logic err_pulse;
  logic dtack_assert;
  logic dtack_release;

  // A cycle begins on a data strobe, not AS alone, so writes (DS lags AS) latch valid data.
  assign cycle_start = !nAS && !(nUDS && nLDS) && addr_hit(M68K_ADDR, ADDR_BASE, ADDR_MASK);
  assign wait_done   = wcnt >= WCNT_W'(WAIT_STATES);
  assign wdog_enable = (state == REQ) || (state == DRAIN);
  assign wdog_clear  = (state_next == IDLE);

  m68k_bus_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .CLK_24M(CLK_24M),
    .nRESET (nRESET),
    .clear  (wdog_clear),
    .enable (wdog_enable),
    .expired(tmo_expired)
  );

  // State register.
  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus one-cycle control strobes for the output registers.
  always_comb begin
    state_next    = state;
    latch_bus     = 1'b0;
    req_drop      = 1'b0;
    rdata_load    = 1'b0;
    rdata_open    = 1'b0;
    err_pulse     = 1'b0;
    dtack_assert  = 1'b0;
    dtack_release = 1'b0;
    unique case (state)
      IDLE: begin
        if (cycle_start) begin
          latch_bus  = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (MEM_ACK) begin
          req_drop = 1'b1;
          if (nAS) begin
            state_next = IDLE;
          end else begin
            rdata_load = !MEM_WE;
            state_next = WAIT;
          end
        end else if (tmo_expired) begin
          req_drop = 1'b1;
          if (nAS) begin
            state_next = IDLE;
          end else begin
            rdata_open = !MEM_WE;
            err_pulse  = 1'b1;
            state_next = WAIT;
          end
        end else if (nAS) begin
          state_next = DRAIN;
        end
      end
      WAIT: begin
        if (nAS) begin
          state_next = IDLE;
        end else if (wait_done) begin
          dtack_assert = 1'b1;
          state_next   = HOLD;
        end
      end
      HOLD: begin
        if (nAS) begin
          dtack_release = 1'b1;
          state_next    = IDLE;
        end
      end
      DRAIN: begin
        if (MEM_ACK || tmo_expired) begin
          req_drop   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Wait-state counter runs from the first REQ cycle through WAIT and saturates.
  always_ff @(posedge CLK_24M) begin
    if (!nRESET || (state_next == IDLE)) begin
      wcnt <= '0;
    end else if (((state == REQ) || (state == WAIT)) && (wcnt != '1)) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  // Capture the bus cycle and hold the backend request until it completes.
  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      MEM_REQ   <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WE    <= 1'b0;
      MEM_BE    <= 2'b00;
      MEM_WDATA <= '0;
    end else if (latch_bus) begin
      MEM_REQ   <= 1'b1;
      MEM_ADDR  <= M68K_ADDR;
      MEM_WE    <= ~M68K_RW;
      MEM_BE    <= {~nUDS, ~nLDS};
      MEM_WDATA <= M68K_DATA_W;
    end else if (req_drop) begin
      MEM_REQ <= 1'b0;
    end
  end

  // Read data back to the CPU: backend data on ack, open bus on forced completion.
  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      M68K_DATA_R <= '0;
    end else if (rdata_load) begin
      M68K_DATA_R <= MEM_RDATA;
    end else if (rdata_open) begin
      M68K_DATA_R <= OPEN_BUS;
    end
  end

  // nDTACK and the timeout flag are registered so no bus input reaches them combinationally.
  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      nDTACK      <= 1'b1;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      TIMEOUT_ERR <= err_pulse;
      if (dtack_assert) begin
        nDTACK <= 1'b0;
      end else if (dtack_release) begin
        nDTACK <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Self-checking bench for m68k_bus_responder: a per-cycle vector table for
// the common bus cycles, then hand-written timeout and reset sequences.
module tb_m68k_bus_responder;

  logic        CLK_24M;
  logic        nRESET;
  logic [22:0] M68K_ADDR;
  logic [15:0] M68K_DATA_W;
  logic [15:0] M68K_DATA_R;
  logic        nAS, nUDS, nLDS, M68K_RW;
  logic        nDTACK;
  logic        MEM_REQ;
  logic [22:0] MEM_ADDR;
  logic        MEM_WE;
  logic [1:0]  MEM_BE;
  logic [15:0] MEM_WDATA;
  logic [15:0] MEM_RDATA;
  logic        MEM_ACK;
  logic        TIMEOUT_ERR;

  int tests_run;
  int tests_failed;

  typedef struct {
    string       name;
    logic        nres, nas, nuds, nlds, rw;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;
    logic        x_req, x_dtack, x_err, x_we;
    logic [1:0]  x_be;
    logic [15:0] x_data_r, x_wdata;
    logic [22:0] x_addr;
  } vec_t;

  vec_t vecs[$];

  m68k_bus_responder #(
    .WAIT_STATES(2),
    .TIMEOUT    (16)
  ) dut (
    .CLK_24M    (CLK_24M),
    .nRESET     (nRESET),
    .M68K_ADDR  (M68K_ADDR),
    .M68K_DATA_W(M68K_DATA_W),
    .M68K_DATA_R(M68K_DATA_R),
    .nAS        (nAS),
    .nUDS       (nUDS),
    .nLDS       (nLDS),
    .M68K_RW    (M68K_RW),
    .nDTACK     (nDTACK),
    .MEM_REQ    (MEM_REQ),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_WE     (MEM_WE),
    .MEM_BE     (MEM_BE),
    .MEM_WDATA  (MEM_WDATA),
    .MEM_RDATA  (MEM_RDATA),
    .MEM_ACK    (MEM_ACK),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  // Free-running 100 MHz-style bench clock; only edge ordering matters.
  initial CLK_24M = 1'b0;
  always #5 CLK_24M = ~CLK_24M;

  // Hard stop in case the run ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: actual running required finished");
    $fatal(1, "[TB] bench did not finish");
  end

  function automatic vec_t mk(input string name,
                              input logic nres, input logic nas, input logic nuds,
                              input logic nlds, input logic rw, input logic [22:0] addr,
                              input logic [15:0] wdata, input logic ack, input logic [15:0] rdata,
                              input logic x_req, input logic x_dtack, input logic x_err,
                              input logic x_we, input logic [1:0] x_be, input logic [15:0] x_data_r,
                              input logic [15:0] x_wdata, input logic [22:0] x_addr);
    vec_t v;
    v.name = name; v.nres = nres; v.nas = nas; v.nuds = nuds; v.nlds = nlds; v.rw = rw;
    v.addr = addr; v.wdata = wdata; v.ack = ack; v.rdata = rdata;
    v.x_req = x_req; v.x_dtack = x_dtack; v.x_err = x_err; v.x_we = x_we; v.x_be = x_be;
    v.x_data_r = x_data_r; v.x_wdata = x_wdata; v.x_addr = x_addr;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK_24M);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    nRESET      = v.nres;
    nAS         = v.nas;
    nUDS        = v.nuds;
    nLDS        = v.nlds;
    M68K_RW     = v.rw;
    M68K_ADDR   = v.addr;
    M68K_DATA_W = v.wdata;
    MEM_ACK     = v.ack;
    MEM_RDATA   = v.rdata;
  endtask

  task automatic check_vector(input vec_t v);
    check_output({v.name, ".req"},    32'(MEM_REQ),     32'(v.x_req));
    check_output({v.name, ".dtack"},  32'(nDTACK),      32'(v.x_dtack));
    check_output({v.name, ".err"},    32'(TIMEOUT_ERR), 32'(v.x_err));
    check_output({v.name, ".we"},     32'(MEM_WE),      32'(v.x_we));
    check_output({v.name, ".be"},     32'(MEM_BE),      32'(v.x_be));
    check_output({v.name, ".data_r"}, 32'(M68K_DATA_R), 32'(v.x_data_r));
    check_output({v.name, ".wdata"},  32'(MEM_WDATA),   32'(v.x_wdata));
    check_output({v.name, ".addr"},   32'(MEM_ADDR),    32'(v.x_addr));
  endtask

  task automatic drive_bus(input logic nas, input logic nds, input logic rw, input logic [22:0] addr);
    nAS       = nas;
    nUDS      = nds;
    nLDS      = nds;
    M68K_RW   = rw;
    M68K_ADDR = addr;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //              name            rst as uds lds rw addr        wdata     ack rdata     req dtk err we be     data_r    wdata     addr
    vecs.push_back(mk("reset",       0, 1, 1, 1, 1, 23'h000000, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 2'b00, 16'h0000, 16'h0000, 23'h000000));
    vecs.push_back(mk("reset_busy",  0, 0, 0, 0, 1, 23'h000100, 16'h0000, 1, 16'h1111, 0, 1, 0, 0, 2'b00, 16'h0000, 16'h0000, 23'h000000));
    vecs.push_back(mk("rd_start",    1, 0, 0, 0, 1, 23'h000100, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 2'b11, 16'h0000, 16'h0000, 23'h000100));
    vecs.push_back(mk("rd_req",      1, 0, 0, 0, 1, 23'h000100, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 2'b11, 16'h0000, 16'h0000, 23'h000100));
    vecs.push_back(mk("rd_ack",      1, 0, 0, 0, 1, 23'h000100, 16'h0000, 1, 16'hBEEF, 0, 1, 0, 0, 2'b11, 16'hBEEF, 16'h0000, 23'h000100));
    vecs.push_back(mk("rd_dtack",    1, 0, 0, 0, 1, 23'h000100, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 2'b11, 16'hBEEF, 16'h0000, 23'h000100));
    vecs.push_back(mk("rd_hold",     1, 0, 0, 0, 1, 23'h000100, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 2'b11, 16'hBEEF, 16'h0000, 23'h000100));
    vecs.push_back(mk("rd_release",  1, 1, 1, 1, 1, 23'h000100, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 2'b11, 16'hBEEF, 16'h0000, 23'h000100));
    vecs.push_back(mk("wr_as_only",  1, 0, 1, 1, 0, 23'h000200, 16'h5A00, 0, 16'h0000, 0, 1, 0, 0, 2'b11, 16'hBEEF, 16'h0000, 23'h000100));
    vecs.push_back(mk("wr_start",    1, 0, 0, 1, 0, 23'h000200, 16'h5A00, 0, 16'h0000, 1, 1, 0, 1, 2'b10, 16'hBEEF, 16'h5A00, 23'h000200));
    vecs.push_back(mk("wr_req",      1, 0, 0, 1, 0, 23'h000200, 16'h5A00, 0, 16'h0000, 1, 1, 0, 1, 2'b10, 16'hBEEF, 16'h5A00, 23'h000200));
    vecs.push_back(mk("wr_ack",      1, 0, 0, 1, 0, 23'h000200, 16'h5A00, 1, 16'h1234, 0, 1, 0, 1, 2'b10, 16'hBEEF, 16'h5A00, 23'h000200));
    vecs.push_back(mk("wr_dtack",    1, 0, 0, 1, 0, 23'h000200, 16'h5A00, 0, 16'h0000, 0, 0, 0, 1, 2'b10, 16'hBEEF, 16'h5A00, 23'h000200));
    vecs.push_back(mk("wr_release",  1, 1, 1, 1, 1, 23'h000200, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 2'b10, 16'hBEEF, 16'h5A00, 23'h000200));
    vecs.push_back(mk("miss_1",      1, 0, 0, 0, 1, 23'h400000, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 2'b10, 16'hBEEF, 16'h5A00, 23'h000200));
    vecs.push_back(mk("miss_2",      1, 0, 0, 0, 1, 23'h400000, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 2'b10, 16'hBEEF, 16'h5A00, 23'h000200));
    vecs.push_back(mk("miss_ack",    1, 0, 0, 0, 1, 23'h400000, 16'h0000, 1, 16'h7777, 0, 1, 0, 1, 2'b10, 16'hBEEF, 16'h5A00, 23'h000200));
    vecs.push_back(mk("miss_rel",    1, 1, 1, 1, 1, 23'h400000, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 2'b10, 16'hBEEF, 16'h5A00, 23'h000200));
    vecs.push_back(mk("ab_start",    1, 0, 0, 0, 1, 23'h000300, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 2'b11, 16'hBEEF, 16'h0000, 23'h000300));
    vecs.push_back(mk("ab_drain0",   1, 1, 1, 1, 1, 23'h000300, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 2'b11, 16'hBEEF, 16'h0000, 23'h000300));
    vecs.push_back(mk("ab_drain1",   1, 1, 1, 1, 1, 23'h000300, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 2'b11, 16'hBEEF, 16'h0000, 23'h000300));
    vecs.push_back(mk("ab_drain2",   1, 1, 1, 1, 1, 23'h000300, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 2'b11, 16'hBEEF, 16'h0000, 23'h000300));
    vecs.push_back(mk("ab_drain3",   1, 1, 1, 1, 1, 23'h000300, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 2'b11, 16'hBEEF, 16'h0000, 23'h000300));
    vecs.push_back(mk("ab_drain4",   1, 1, 1, 1, 1, 23'h000300, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 2'b11, 16'hBEEF, 16'h0000, 23'h000300));
    vecs.push_back(mk("ab_ack",      1, 1, 1, 1, 1, 23'h000300, 16'h0000, 1, 16'hDEAD, 0, 1, 0, 0, 2'b11, 16'hBEEF, 16'h0000, 23'h000300));
    vecs.push_back(mk("ab_idle",     1, 1, 1, 1, 1, 23'h000300, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 2'b11, 16'hBEEF, 16'h0000, 23'h000300));
    vecs.push_back(mk("rd2_start",   1, 0, 0, 0, 1, 23'h000100, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 2'b11, 16'hBEEF, 16'h0000, 23'h000100));
    vecs.push_back(mk("rd2_ack",     1, 0, 0, 0, 1, 23'h000100, 16'h0000, 1, 16'h0042, 0, 1, 0, 0, 2'b11, 16'h0042, 16'h0000, 23'h000100));
    vecs.push_back(mk("rd2_wait",    1, 0, 0, 0, 1, 23'h000100, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 2'b11, 16'h0042, 16'h0000, 23'h000100));
    vecs.push_back(mk("rd2_dtack",   1, 0, 0, 0, 1, 23'h000100, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 2'b11, 16'h0042, 16'h0000, 23'h000100));
    vecs.push_back(mk("rd2_release", 1, 1, 1, 1, 1, 23'h000100, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 2'b11, 16'h0042, 16'h0000, 23'h000100));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      tick();
      check_vector(vecs[i]);
    end

    // Dead backend: forced completion after 16 REQ cycles.
    MEM_ACK   = 1'b0;
    MEM_RDATA = 16'h0000;
    drive_bus(1'b0, 1'b0, 1'b1, 23'h000400);
    tick();
    check_output("tmo_start.req", 32'(MEM_REQ), 32'd1);
    for (int i = 1; i < 16; i++) begin
      tick();
      check_output($sformatf("tmo_wait%0d.req", i), 32'(MEM_REQ), 32'd1);
      check_output($sformatf("tmo_wait%0d.err", i), 32'(TIMEOUT_ERR), 32'd0);
      check_output($sformatf("tmo_wait%0d.dtack", i), 32'(nDTACK), 32'd1);
    end
    tick();
    check_output("tmo_fire.req", 32'(MEM_REQ), 32'd0);
    check_output("tmo_fire.err", 32'(TIMEOUT_ERR), 32'd1);
    check_output("tmo_fire.data_r", 32'(M68K_DATA_R), 32'h0000FFFF);
    tick();
    check_output("tmo_after.err", 32'(TIMEOUT_ERR), 32'd0);
    check_output("tmo_after.dtack", 32'(nDTACK), 32'd0);
    drive_bus(1'b1, 1'b1, 1'b1, 23'h000400);
    tick();
    check_output("tmo_release.dtack", 32'(nDTACK), 32'd1);

    // Reset while a request is outstanding, then a late ack once reset is released.
    drive_bus(1'b0, 1'b0, 1'b1, 23'h000500);
    tick();
    check_output("rst_start.req", 32'(MEM_REQ), 32'd1);
    tick();
    check_output("rst_req.req", 32'(MEM_REQ), 32'd1);
    nRESET = 1'b0;
    tick();
    check_output("rst_mid.req", 32'(MEM_REQ), 32'd0);
    check_output("rst_mid.dtack", 32'(nDTACK), 32'd1);
    check_output("rst_mid.data_r", 32'(M68K_DATA_R), 32'd0);
    check_output("rst_mid.be", 32'(MEM_BE), 32'd0);
    check_output("rst_mid.we", 32'(MEM_WE), 32'd0);
    check_output("rst_mid.addr", 32'(MEM_ADDR), 32'd0);
    check_output("rst_mid.wdata", 32'(MEM_WDATA), 32'd0);
    check_output("rst_mid.err", 32'(TIMEOUT_ERR), 32'd0);
    nRESET = 1'b1;
    drive_bus(1'b1, 1'b1, 1'b1, 23'h000500);
    MEM_ACK   = 1'b1;
    MEM_RDATA = 16'hCAFE;
    tick();
    check_output("rst_late_ack.req", 32'(MEM_REQ), 32'd0);
    check_output("rst_late_ack.dtack", 32'(nDTACK), 32'd1);
    check_output("rst_late_ack.data_r", 32'(M68K_DATA_R), 32'd0);
    MEM_ACK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output($sformatf("rst_quiet%0d.dtack", i), 32'(nDTACK), 32'd1);
      check_output($sformatf("rst_quiet%0d.req", i), 32'(MEM_REQ), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- Target-side 68000 bus responder for the NeoGeo core; sits between the 68k bus (AS/UDS/LDS/RW/address/data) and a memory or peripheral backend with a req/ack handshake.
- Decodes an address window, converts a 68k bus cycle into one backend transaction, and inserts a programmable minimum wait-state count.
- Generates nDTACK and drives read data back to the CPU. A timeout watchdog prevents a dead backend from hanging the CPU.

Parameters:
- ADDR_BASE, 23'h000000, word-address base of the decoded window (compared against M68K_ADDR[23:1]).
- ADDR_MASK, 23'h780000, bits of M68K_ADDR that must equal ADDR_BASE for a match.
- WAIT_STATES, 2, minimum CLK_24M cycles from MEM_REQ rise to nDTACK fall, range 0-15.
- TIMEOUT, 255, cycles without MEM_ACK before forced completion, range 16-1023.

Ports:
- CLK_24M  in  1  sole clock; all logic on posedge.
- nRESET  in  1  synchronous active-low reset, sampled on posedge CLK_24M.
- M68K_ADDR  in  23  CPU word address [23:1].
- M68K_DATA_W  in  16  CPU write data.
- M68K_DATA_R  out  16  read data to CPU; registered.
- nAS, nUDS, nLDS  in  1 each  CPU strobes, active-low.
- M68K_RW  in  1  1 = read, 0 = write.
- nDTACK  out  1  active-low acknowledge; high when idle or not selected.
- MEM_REQ  out  1  backend request; level, held until MEM_ACK.
- MEM_ADDR  out  23  latched word address.
- MEM_WE  out  1  latched ~M68K_RW.
- MEM_BE  out  2  latched {~nUDS, ~nLDS}.
- MEM_WDATA  out  16  latched write data.
- MEM_RDATA  in  16  backend read data; valid with MEM_ACK.
- MEM_ACK  in  1  one-cycle completion pulse.
- TIMEOUT_ERR  out  1  one-cycle pulse on forced completion.

Behaviour:
- Reset (nRESET=0 at an edge):
  - State=IDLE; nDTACK=1, MEM_REQ=0, MEM_WE=0, MEM_BE=0, MEM_ADDR=0, MEM_WDATA=0, M68K_DATA_R=16'h0000, TIMEOUT_ERR=0; counters cleared.
  - A reset mid-transaction drops MEM_REQ immediately. A late MEM_ACK arriving in IDLE is ignored.
- Cycle start: in IDLE, when nAS=0, (nUDS&nLDS)=0 and (M68K_ADDR & ADDR_MASK)==(ADDR_BASE & ADDR_MASK):
  - Latch address, RW, byte enables and write data.
  - Go to REQ; MEM_REQ=1 from the next cycle.
  - Starting on data-strobe (not AS alone) covers the 68k write cycle, where DS lags AS.
- REQ:
  - MEM_REQ held high; wcnt and tcnt increment each cycle from 0, starting in the cycle MEM_REQ first reads 1.
  - On MEM_ACK: MEM_REQ=0 next edge; M68K_DATA_R<=MEM_RDATA if read (unchanged on write); set ack_seen; go to WAIT.
  - If tcnt==TIMEOUT-1 with no ack: MEM_REQ=0, M68K_DATA_R<=16'hFFFF on read, TIMEOUT_ERR pulses one cycle, go to WAIT.
  - MEM_ACK and timeout in the same cycle: ack wins, no TIMEOUT_ERR.
- WAIT: when wcnt>=WAIT_STATES, nDTACK<=0 at the next edge and go to HOLD. With WAIT_STATES=0 and an ack on the first REQ cycle, nDTACK falls two edges after the start edge.
- HOLD: nDTACK stays 0 until nAS is sampled 1. At that edge nDTACK<=1 and state goes to IDLE. A new cycle can start no earlier than the following edge.
- Abort (nAS sampled 1 in REQ or WAIT):
  - nDTACK is never asserted for that cycle.
  - From REQ: go to DRAIN, keep MEM_REQ until MEM_ACK or timeout (no TIMEOUT_ERR), then IDLE.
  - From WAIT: go directly to IDLE.
- Counters: wcnt 4-bit and tcnt 10-bit, both saturating; cleared on entry to IDLE.
- nDTACK, M68K_DATA_R and all MEM_* outputs are registered; no combinational path from bus inputs to outputs.
- Address mismatch: no state change; nDTACK remains 1. The external DTACK combiner ANDs all responders.

Decomposition:
- Shared package neo_bus_pkg:
  - state enum {IDLE, REQ, WAIT, HOLD, DRAIN};
  - widths ADDR_W=23 and DATA_W=16;
  - constant OPEN_BUS=16'hFFFF.
- One natural sub-module, m68k_bus_wdog, holds tcnt plus the timeout compare and exposes clear/enable/expired.
- The FSM, latches and wait counter stay in the top module.

Test Plan:
- Word read, WAIT_STATES=2: addr 23'h000100, MEM_ACK with 16'hBEEF one cycle after MEM_REQ -> MEM_BE=2'b11, MEM_WE=0, nDTACK low 3 edges after MEM_REQ rise, M68K_DATA_R=16'hBEEF; nDTACK high one edge after nAS=1.
- Upper-byte write: nUDS=0, nLDS=1, data 16'h5A00, with DS one cycle after AS -> MEM_REQ rises one edge after DS, MEM_BE=2'b10, MEM_WE=1, MEM_WDATA=16'h5A00.
- Dead backend, TIMEOUT=16 -> MEM_REQ drops after 16 cycles, TIMEOUT_ERR=1 for exactly one cycle, M68K_DATA_R=16'hFFFF, nDTACK asserted.
- Address 23'h400000 outside the window -> MEM_REQ stays 0 and nDTACK stays 1 for the whole cycle.
- nAS released in REQ, ack 5 cycles later -> DRAIN holds MEM_REQ until the ack, nDTACK never low, state IDLE afterwards.
- nRESET=0 while in REQ, ack arriving after reset is released -> all outputs at reset values, ack ignored, no spurious nDTACK.
